// File: rtl/dac_pkg.sv
// ----------------------------------------------------------------------------
// dac_pkg
// Shared types and default sizing for the DAC waveform generator.
//   wave_mode_t : SAW, TRI, SQUARE, HOLD (matches the 2-bit mode encoding)
//   dir_t       : triangle direction, UP (0) / DOWN (1)
// ----------------------------------------------------------------------------
package dac_pkg;

    localparam int DAC_N_DEFAULT      = 8;
    localparam int DAC_STEP_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        SAW    = 2'd0,
        TRI    = 2'd1,
        SQUARE = 2'd2,
        HOLD   = 2'd3
    } wave_mode_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage : dac_pkg

// File: rtl/dac_wave_gen_if.sv
// ----------------------------------------------------------------------------
// dac_wave_gen_if
// Control/status bundle between the sound controller and the waveform
// generator.
//   master : controller side, drives en/clear/mode/step/limit, sees the code
//   slave  : generator side, drives dacCount/dir/wrap
// Signals:
//   en       advance strobe          clear   synchronous clear
//   mode     wave_mode_t             step    increment (STEP_W bits)
//   limit    inclusive peak code     dacCount registered DAC code
//   dir      triangle direction      wrap    end-of-period pulse
// ----------------------------------------------------------------------------
interface dac_wave_gen_if #(
    parameter int N      = dac_pkg::DAC_N_DEFAULT,
    parameter int STEP_W = dac_pkg::DAC_STEP_W_DEFAULT
);
    import dac_pkg::*;

    logic              en;
    logic              clear;
    wave_mode_t        mode;
    logic [STEP_W-1:0] step;
    logic [N-1:0]      limit;
    logic [N-1:0]      dacCount;
    dir_t              dir;
    logic              wrap;

    modport master (
        output en, clear, mode, step, limit,
        input  dacCount, dir, wrap
    );

    modport slave (
        input  en, clear, mode, step, limit,
        output dacCount, dir, wrap
    );

endinterface : dac_wave_gen_if

// File: rtl/dac_step_unit.sv
// ----------------------------------------------------------------------------
// dac_step_unit
// Purely combinational next-phase computation for one advance.
// Inputs : acc (current phase), dir, mode, step, limit
// Outputs: acc_next, dir_next, wrap_next
// All comparisons are done N+1 bits wide so acc+step can never alias back
// into range. A zero step is a no-op in every mode (no move, no wrap, no
// direction change). HOLD leaves everything untouched.
// ----------------------------------------------------------------------------
module dac_step_unit
    import dac_pkg::*;
#(
    parameter int N      = DAC_N_DEFAULT,
    parameter int STEP_W = DAC_STEP_W_DEFAULT
) (
    input  logic [N-1:0]      acc,
    input  dir_t              dir,
    input  wave_mode_t        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit,
    output logic [N-1:0]      acc_next,
    output dir_t              dir_next,
    output logic              wrap_next
);

    logic [N:0] acc_w;
    logic [N:0] step_w;
    logic [N:0] limit_w;
    logic [N:0] sum_w;

    assign acc_w   = {1'b0, acc};
    assign step_w  = {{(N+1-STEP_W){1'b0}}, step};
    assign limit_w = {1'b0, limit};
    assign sum_w   = acc_w + step_w;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        acc_next  = acc;
        dir_next  = dir;
        wrap_next = 1'b0;

        if (step != '0) begin
            case (mode)
                SAW, SQUARE: begin
                    // Also covers acc > limit after limit was lowered.
                    if (sum_w > limit_w) begin
                        acc_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        acc_next = sum_w[N-1:0];
                    end
                end
                TRI: begin
                    if (acc_w > limit_w) begin
                        // Limit lowered underneath us: clamp and start down.
                        acc_next = limit;
                        dir_next = DOWN;
                    end else if (dir == UP) begin
                        if (sum_w >= limit_w) begin
                            acc_next = limit;
                            dir_next = DOWN;
                        end else begin
                            acc_next = sum_w[N-1:0];
                        end
                    end else begin
                        if (acc_w <= step_w) begin
                            acc_next  = '0;
                            dir_next  = UP;
                            wrap_next = 1'b1;
                        end else begin
                            // acc > step here, so the N-bit difference is exact.
                            acc_next = acc - step_w[N-1:0];
                        end
                    end
                end
                default: begin
                    // HOLD: defaults already freeze everything.
                end
            endcase
        end
    end

endmodule : dac_step_unit

// File: rtl/dac_wave_gen.sv
// ----------------------------------------------------------------------------
// dac_wave_gen
// N-bit DAC code generator: sawtooth, triangle, square or hold, advancing one
// step per cycle while en is high.
// Ports:
//   clk   system clock
//   nRst  asynchronous active-low reset
//   bus   dac_wave_gen_if.slave (en, clear, mode, step, limit in;
//         dacCount, dir, wrap out; all outputs registered)
// Build option:
//   DAC_IDLE_CLEAR_EN  when defined, en=0 acts like clear (legacy ramp: count
//                      only while the strobe is held). Undefined: en=0 holds.
// ----------------------------------------------------------------------------
module dac_wave_gen
    import dac_pkg::*;
#(
    parameter int N      = DAC_N_DEFAULT,
    parameter int STEP_W = DAC_STEP_W_DEFAULT
) (
    input logic           clk,
    input logic           nRst,
    dac_wave_gen_if.slave bus
);

    logic [N-1:0] acc_q;
    dir_t         dir_q;
    logic [N-1:0] dac_q;
    logic         wrap_q;

    logic [N-1:0] acc_next;
    dir_t         dir_next;
    logic         wrap_next;
    logic [N-1:0] dac_next;
    logic [N-1:0] half_limit;
    logic         do_clear;
    logic         advance;

    dac_step_unit #(
        .N      (N),
        .STEP_W (STEP_W)
    ) u_step (
        .acc       (acc_q),
        .dir       (dir_q),
        .mode      (bus.mode),
        .step      (bus.step),
        .limit     (bus.limit),
        .acc_next  (acc_next),
        .dir_next  (dir_next),
        .wrap_next (wrap_next)
    );

`ifdef DAC_IDLE_CLEAR_EN
    assign do_clear = bus.clear | ~bus.en;
`else
    assign do_clear = bus.clear;
`endif

    // HOLD freezes the output code too, so it never counts as an advance.
    assign advance    = bus.en && (bus.mode != HOLD);
    assign half_limit = {1'b0, bus.limit[N-1:1]};

    // Square maps the new phase onto a two-level output at half the limit.
    assign dac_next = (bus.mode == SQUARE)
                    ? ((acc_next >= half_limit) ? bus.limit : '0)
                    : acc_next;

    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of its neighbours.
        if (!nRst) begin
            acc_q  <= '0;
            dir_q  <= UP;
            dac_q  <= '0;
            wrap_q <= 1'b0;
        end else if (do_clear) begin
            acc_q  <= '0;
            dir_q  <= UP;
            dac_q  <= '0;
            wrap_q <= 1'b0;
        end else if (advance) begin
            acc_q  <= acc_next;
            dir_q  <= dir_next;
            dac_q  <= dac_next;
            wrap_q <= wrap_next;
        end else begin
            // Idle or HOLD: state frozen, wrap is only ever a one-cycle pulse.
            wrap_q <= 1'b0;
        end
    end

    assign bus.dacCount = dac_q;
    assign bus.dir      = dir_q;
    assign bus.wrap     = wrap_q;

endmodule : dac_wave_gen

// File: tb/tb_dac_wave_gen.sv
// ----------------------------------------------------------------------------
// tb_dac_wave_gen
// Self-checking bench for dac_wave_gen: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against an
// arithmetic reference model of the waveform rules.
// Honours DAC_IDLE_CLEAR_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_dac_wave_gen;
    import dac_pkg::*;

    localparam int N      = 8;
    localparam int STEP_W = 4;
`ifdef DAC_IDLE_CLEAR_EN
    localparam bit IDLE_CLEAR = 1'b1;
`else
    localparam bit IDLE_CLEAR = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nRst = 1'b0;

    dac_wave_gen_if #(.N(N), .STEP_W(STEP_W)) bus ();

    dac_wave_gen #(.N(N), .STEP_W(STEP_W)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (integer arithmetic) ----------------
    int m_acc  = 0;
    int m_dir  = 0;
    int m_dac  = 0;
    int m_wrap = 0;

    task automatic model_zero();
        m_acc = 0; m_dir = 0; m_dac = 0; m_wrap = 0;
    endtask

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            model_zero();
        end else begin
            int md, st, lim;
            md  = int'(bus.mode);
            st  = int'(bus.step);
            lim = int'(bus.limit);
            if (bus.clear || (IDLE_CLEAR && !bus.en)) begin
                model_zero();
            end else if (!bus.en || md == 3) begin
                m_wrap = 0;
            end else begin
                m_wrap = 0;
                if (st != 0) begin
                    if (md == 0 || md == 2) begin
                        if (m_acc + st > lim) begin m_acc = 0; m_wrap = 1; end
                        else m_acc = m_acc + st;
                    end else if (m_acc > lim) begin
                        m_acc = lim; m_dir = 1;
                    end else if (m_dir == 0) begin
                        if (m_acc + st >= lim) begin m_acc = lim; m_dir = 1; end
                        else m_acc = m_acc + st;
                    end else begin
                        if (m_acc <= st) begin m_acc = 0; m_dir = 0; m_wrap = 1; end
                        else m_acc = m_acc - st;
                    end
                end
                if (md == 2) m_dac = (m_acc >= lim / 2) ? lim : 0;
                else         m_dac = m_acc;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_dacCount", int'(bus.dacCount), m_dac);
            check("cmp_dir",      int'(bus.dir),      m_dir);
            check("cmp_wrap",     int'(bus.wrap),     m_wrap);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drive(input wave_mode_t md, input int st, input int lim, input bit e);
        bus.mode  = md;
        bus.step  = STEP_W'(st);
        bus.limit = N'(lim);
        bus.en    = e;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
    endtask

    int tri_dac  [7] = '{3, 6, 8, 5, 2, 0, 3};
    int tri_dir  [7] = '{0, 0, 1, 1, 1, 0, 0};
    int tri_wrap [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        int wraps;
        int a;
        int exp_dac;

        bus.clear = 1'b0;
        drive(SAW, 0, 0, 1'b0);

        // Reset state
        #12;
        check("reset_dac",  int'(bus.dacCount), 0);
        check("reset_dir",  int'(bus.dir),      0);
        check("reset_wrap", int'(bus.wrap),     0);
        @(negedge clk);
        nRst   = 1'b1;
        cmp_en = 1'b1;

        // Ramp to 37, then asynchronous reset mid-cycle
        drive(SAW, 15, 200, 1'b1);
        tick(2);
        bus.step = STEP_W'(7);
        tick(1);
        check("ramp_37", int'(bus.dacCount), 37);
        #2 nRst = 1'b0;
        #1;
        check("async_rst_dac",  int'(bus.dacCount), 0);
        check("async_rst_dir",  int'(bus.dir),      0);
        check("async_rst_wrap", int'(bus.wrap),     0);
        @(negedge clk);
        nRst   = 1'b1;
        bus.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("hold_after_rst", int'(bus.dacCount), 0);
        end

        // SAW wrap: 3,6,9,0 repeating, four wraps in 16 cycles
        do_clear();
        drive(SAW, 3, 10, 1'b1);
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            exp_dac = (i % 4 == 3) ? 0 : (i % 4 + 1) * 3;
            check("saw_dac",  int'(bus.dacCount), exp_dac);
            check("saw_wrap", int'(bus.wrap), (exp_dac == 0) ? 1 : 0);
            wraps += int'(bus.wrap);
        end
        check("saw_wrap_count", wraps, 4);

        // TRI turnaround: 3,6,8,5,2,0,3
        do_clear();
        drive(TRI, 3, 8, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1);
            check("tri_dac",  int'(bus.dacCount), tri_dac[i]);
            check("tri_dir",  int'(bus.dir),      tri_dir[i]);
            check("tri_wrap", int'(bus.wrap),     tri_wrap[i]);
        end

        // SQUARE: 0 below 100, 200 at or above, wrap back to 0 past 195
        do_clear();
        drive(SQUARE, 15, 200, 1'b1);
        a = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            a = (a + 15 > 200) ? 0 : a + 15;
            check("sq_dac",  int'(bus.dacCount), (a >= 100) ? 200 : 0);
            check("sq_wrap", int'(bus.wrap), (a == 0) ? 1 : 0);
        end

        // step=0: no movement, no wrap
        do_clear();
        drive(SAW, 5, 50, 1'b1);
        tick(3);
        bus.step = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("step0_dac",  int'(bus.dacCount), 15);
            check("step0_wrap", int'(bus.wrap),     0);
        end

        // limit lowered under acc=120, SAW
        do_clear();
        drive(SAW, 15, 200, 1'b1);
        tick(8);
        check("saw_pre_lower", int'(bus.dacCount), 120);
        bus.limit = N'(50);
        tick(1);
        check("saw_lower_dac",  int'(bus.dacCount), 0);
        check("saw_lower_wrap", int'(bus.wrap),     1);

        // limit lowered under acc=120, TRI
        do_clear();
        drive(TRI, 15, 200, 1'b1);
        tick(8);
        bus.limit = N'(50);
        tick(1);
        check("tri_lower_dac",  int'(bus.dacCount), 50);
        check("tri_lower_dir",  int'(bus.dir),      1);
        check("tri_lower_wrap", int'(bus.wrap),     0);

        // clear beats en
        do_clear();
        drive(SAW, 7, 200, 1'b1);
        tick(1);
        check("pre_clear", int'(bus.dacCount), 7);
        bus.clear = 1'b1;
        tick(1);
        bus.clear = 1'b0;
        check("clear_over_en", int'(bus.dacCount), 0);

        // dropping en at acc=9
        do_clear();
        drive(SAW, 9, 200, 1'b1);
        tick(1);
        bus.en = 1'b0;
        tick(3);
        check("idle_en0", int'(bus.dacCount), IDLE_CLEAR ? 0 : 9);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            bus.clear = ($urandom_range(31, 0) == 0);
            bus.en    = ($urandom_range(3, 0) != 0);
            if ($urandom_range(15, 0) == 0)
                bus.mode = wave_mode_t'($urandom_range(3, 0));
            if ($urandom_range(7, 0) == 0)
                bus.step = '0;
            else if ($urandom_range(3, 0) == 0)
                bus.step = STEP_W'($urandom_range(15, 1));
            if ($urandom_range(31, 0) == 0)
                bus.limit = ($urandom_range(7, 0) == 0) ? N'($urandom_range(3, 0))
                                                        : N'($urandom_range(255, 0));
            if ($urandom_range(499, 0) == 0) begin
                #2 nRst = 1'b0;
                #2 nRst = 1'b1;
            end
            tick(1);
        end

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dac_wave_gen
